// File: rtl/lcd1602_responder.sv
// HD44780-compatible LCD1602 display-side bus responder: 2x16 DDRAM, busy timing,
// status/data reads and a registered mirror port for on-chip consumers.
module lcd1602_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 76500
) (
    input  logic       clock_50mhz,
    input  logic       reset,
    input  logic       rs_pin,
    input  logic       rw_pin,
    input  logic       en_pin,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       bus_err,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [6:0] cursor_addr
);
    localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BUSY_LD  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, FILL, BUSY} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [4:0]                  fill_idx;
    logic [6:0]                  ac;
    logic                        inc_dir, shift_en, dl_bit, n_bit, cgram_sel;
    logic                        lat_rs, lat_rw, en_prev;
    logic [7:0]                  lat_d;
    logic [SYNC_STAGES-1:0][10:0] sync_q;
    logic                        rs_s, rw_s, en_s;
    logic [7:0]                  d_s;
    logic [7:0]                  ddram [32];
    logic                        ram_we;
    logic [4:0]                  ram_waddr;
    logic [7:0]                  ram_wdata;

    function automatic logic in_win(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    function automatic logic [4:0] win_idx(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // Two-line address map; anything outside the legal ranges snaps to the wrap edge.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic       in_rng;
        logic [6:0] r;
        in_rng = (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
        if (inc) begin
            if (!in_rng || a == 7'h67) r = 7'h00;
            else if (a == 7'h27)       r = 7'h40;
            else                       r = a + 7'd1;
        end else begin
            if (!in_rng || a == 7'h00) r = 7'h67;
            else if (a == 7'h40)       r = 7'h27;
            else                       r = a - 7'd1;
        end
        return r;
    endfunction

    always_ff @(posedge clock_50mhz) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rs_pin, rw_pin, en_pin, data_in};
    end

    assign {rs_s, rw_s, en_s, d_s} = sync_q[SYNC_STAGES-1];
    assign busy        = (state != IDLE);
    assign cursor_addr = ac;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = fill_idx;
        ram_wdata = 8'h20;
        if (!reset) begin
            if (state == FILL) begin
                ram_we = 1'b1;
            end else if (state == EXEC && lat_rs && !lat_rw && !cgram_sel && in_win(ac)) begin
                ram_we    = 1'b1;
                ram_waddr = win_idx(ac);
                ram_wdata = lat_d;
            end
        end
    end

    // Mirror read samples before any same-cycle write lands.
    always_ff @(posedge clock_50mhz) begin
        if (ram_we) ddram[ram_waddr] <= ram_wdata;
        if (reset) rd_char <= 8'h00;
        else       rd_char <= ddram[rd_addr];
    end

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            state     <= FILL;
            cnt       <= '0;
            fill_idx  <= '0;
            ac        <= '0;
            inc_dir   <= 1'b1;
            shift_en  <= 1'b0;
            dl_bit    <= 1'b1;
            n_bit     <= 1'b1;
            cgram_sel <= 1'b0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            bus_err   <= 1'b0;
            lat_rs    <= 1'b0;
            lat_rw    <= 1'b0;
            lat_d     <= 8'h00;
            en_prev   <= 1'b0;
        end else begin
            en_prev <= en_s;
            bus_err <= 1'b0;
            case (state)
                FILL: begin
                    fill_idx <= fill_idx + 5'd1;
                    if (fill_idx == 5'd31) begin
                        state <= BUSY;
                        cnt   <= CLEAR_LD;
                    end
                end
                BUSY: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                EXEC: begin
                    state <= BUSY;
                    cnt   <= BUSY_LD;
                    if (lat_rs) begin
                        ac <= ac_step(ac, inc_dir);
                    end else begin
                        casez (lat_d)
                            8'b1???????: begin ac <= lat_d[6:0]; cgram_sel <= 1'b0; end
                            8'b01??????: cgram_sel <= 1'b1;
                            8'b001?????: begin dl_bit <= lat_d[4]; n_bit <= lat_d[3]; end
                            8'b0001????: if (!lat_d[3]) ac <= ac_step(ac, lat_d[2]);
                            8'b00001???: {disp_on, cursor_on, blink_on} <= lat_d[2:0];
                            8'b000001??: begin inc_dir <= lat_d[1]; shift_en <= lat_d[0]; end
                            8'b0000001?: begin ac <= '0; cnt <= CLEAR_LD; end
                            8'b00000001: begin
                                ac       <= '0;
                                inc_dir  <= 1'b1;
                                state    <= FILL;
                                fill_idx <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase

            // Status reads are always answered; data reads obey the same busy rules as writes.
            if (en_s && !en_prev && rw_s) begin
                if (!rs_s) begin
                    data_out <= {busy, ac};
                    data_oe  <= 1'b1;
                end else if (state == IDLE) begin
                    data_out <= in_win(ac) ? ddram[win_idx(ac)] : 8'h20;
                    data_oe  <= 1'b1;
                end else begin
                    bus_err <= 1'b1;
                end
            end
            if (!en_s && en_prev) begin
                data_oe <= 1'b0;
                if (!rw_s || rs_s) begin
                    if (state == IDLE) begin
                        state  <= EXEC;
                        lat_rs <= rs_s;
                        lat_rw <= rw_s;
                        lat_d  <= d_s;
                    end else begin
                        bus_err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd1602_responder.sv
// Randomized bench for lcd1602_responder against a display-level model (cell array + address counter).
module tb_lcd1602_responder;
    localparam int BUSY_N  = 20;
    localparam int CLEAR_N = 100;

    logic       clk = 1'b0, reset = 1'b1, rs_pin = 1'b0, rw_pin = 1'b0, en_pin = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] data_out, rd_char;
    logic       data_oe, busy, bus_err, disp_on, cursor_on, blink_on;
    logic [6:0] cursor_addr;

    lcd1602_responder #(.SYNC_STAGES(2), .BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
        .clock_50mhz(clk), .reset(reset), .rs_pin(rs_pin), .rw_pin(rw_pin), .en_pin(en_pin),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .busy(busy), .bus_err(bus_err),
        .rd_addr(rd_addr), .rd_char(rd_char), .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .cursor_addr(cursor_addr));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, err_pulses = 0;
    always @(negedge clk) if (bus_err === 1'b1) err_pulses++;

    // Reference model: what the display should hold, in display terms.
    logic [7:0] mem [32];
    logic [6:0] m_ac;
    bit         m_id, m_cg, m_d, m_c, m_b;

    function automatic logic [6:0] m_next(input logic [6:0] a, input bit inc);
        int  v = int'(a);
        bit  legal = (v <= 'h27) || (v >= 'h40 && v <= 'h67);
        if (inc) return !legal || v == 'h67 ? 7'h00 : (v == 'h27 ? 7'h40 : 7'(v + 1));
        return !legal || v == 0 ? 7'h67 : (v == 'h40 ? 7'h27 : 7'(v - 1));
    endfunction

    function automatic int m_idx(input logic [6:0] a);
        int v = int'(a);
        if (v < 16) return v;
        if (v >= 'h40 && v < 'h50) return 16 + v - 'h40;
        return -1;
    endfunction

    task automatic m_reset();
        foreach (mem[i]) mem[i] = 8'h20;
        m_ac = 0; m_id = 1; m_cg = 0; m_d = 0; m_c = 0; m_b = 0;
    endtask

    task automatic m_cmd(input logic [7:0] d);
        if (d[7])      begin m_ac = d[6:0]; m_cg = 0; end
        else if (d[6]) m_cg = 1;
        else if (d[5]) ;
        else if (d[4]) begin if (!d[3]) m_ac = m_next(m_ac, d[2]); end
        else if (d[3]) begin m_d = d[2]; m_c = d[1]; m_b = d[0]; end
        else if (d[2]) m_id = d[1];
        else if (d[1]) m_ac = 0;
        else if (d[0]) begin foreach (mem[i]) mem[i] = 8'h20; m_ac = 0; m_id = 1; end
    endtask

    task automatic m_data(input logic [7:0] d);
        int i = m_idx(m_ac);
        if (!m_cg && i >= 0) mem[i] = d;
        m_ac = m_next(m_ac, m_id);
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        while (busy && g < 1000) begin @(negedge clk); g++; end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL %s: busy timeout, busy=%b required 0", nm, busy); end
    endtask

    // One full EN strobe, then wait out busy; nb returns the number of busy cycles seen.
    task automatic bus_op(input bit rs, input bit rw, input logic [7:0] d, output int nb);
        nb = 0;
        rs_pin = rs; rw_pin = rw; data_in = d; en_pin = 1'b1;
        repeat (4) begin @(negedge clk); nb += int'(busy); end
        en_pin = 1'b0;
        repeat (4) begin @(negedge clk); nb += int'(busy); end
        for (int g = 0; g < 1000 && busy; g++) begin @(negedge clk); nb += int'(busy); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL bus_op %h: busy timeout", d); end
    endtask

    task automatic peek(input int a, output logic [7:0] v);
        rd_addr = 5'(a);
        @(negedge clk);
        v = rd_char;
    endtask

    task automatic test_reset();
        int nb = 0;
        logic [7:0] v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({data_out, data_oe, bus_err, rd_char} !== 18'h0) begin
            n_err++; $display("FAIL reset_outs: dout=%h oe=%b err=%b rdc=%h required 0", data_out, data_oe, bus_err, rd_char);
        end
        n_vec++;
        if ({disp_on, cursor_on, blink_on, cursor_addr} !== 10'h0) begin
            n_err++; $display("FAIL reset_ctrl: dcb=%b%b%b ac=%h required 0", disp_on, cursor_on, blink_on, cursor_addr);
        end
        reset = 1'b0;
        for (int i = 0; i < 32 + CLEAR_N + 40; i++) begin nb += int'(busy); @(negedge clk); end
        n_vec++;
        if (nb != 32 + CLEAR_N) begin n_err++; $display("FAIL reset_busy_len: %0d cycles required %0d", nb, 32 + CLEAR_N); end
        m_reset();
        n_vec++;
        if (cursor_addr !== m_ac) begin n_err++; $display("FAIL reset_ac: %h required %h", cursor_addr, m_ac); end
        for (int i = 0; i < 32; i++) begin
            peek(i, v);
            n_vec++;
            if (v !== 8'h20) begin n_err++; $display("FAIL reset_fill[%0d]: %h required 20", i, v); end
        end
    endtask

    task automatic test_init_seq();
        int nb;
        logic [7:0] v;
        logic [7:0] cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h80};
        foreach (cmds[i]) begin
            bus_op(0, 0, cmds[i], nb);
            m_cmd(cmds[i]);
            if (i == 0) begin
                n_vec++;
                if (nb != 1 + BUSY_N) begin n_err++; $display("FAIL cmd_busy_len: %0d required %0d", nb, 1 + BUSY_N); end
            end
        end
        bus_op(1, 0, 8'h41, nb); m_data(8'h41);
        n_vec++;
        if ({disp_on, cursor_on, blink_on} !== {m_d, m_c, m_b}) begin
            n_err++; $display("FAIL init_dcb: %b%b%b required %b%b%b", disp_on, cursor_on, blink_on, m_d, m_c, m_b);
        end
        peek(0, v);
        n_vec++;
        if (v !== mem[0]) begin n_err++; $display("FAIL init_char: %h required %h", v, mem[0]); end
        n_vec++;
        if (cursor_addr !== m_ac) begin n_err++; $display("FAIL init_ac: %h required %h", cursor_addr, m_ac); end
    endtask

    task automatic test_wrap();
        int nb;
        logic [7:0] v;
        bus_op(0, 0, 8'hCF, nb); m_cmd(8'hCF);
        bus_op(1, 0, 8'h5A, nb); m_data(8'h5A);
        bus_op(1, 0, 8'h51, nb); m_data(8'h51);
        peek(31, v);
        n_vec++;
        if (v !== mem[31]) begin n_err++; $display("FAIL wrap_cell31: %h required %h", v, mem[31]); end
        n_vec++;
        if (cursor_addr !== m_ac) begin n_err++; $display("FAIL wrap_ac_row1: %h required %h", cursor_addr, m_ac); end
        bus_op(0, 0, 8'hA7, nb); m_cmd(8'hA7);
        bus_op(1, 0, 8'h2A, nb); m_data(8'h2A);
        n_vec++;
        if (cursor_addr !== m_ac) begin n_err++; $display("FAIL wrap_27_40: %h required %h", cursor_addr, m_ac); end
    endtask

    task automatic test_entry_dec();
        int nb;
        logic [7:0] v;
        bus_op(0, 0, 8'h04, nb); m_cmd(8'h04);
        bus_op(0, 0, 8'h80, nb); m_cmd(8'h80);
        bus_op(1, 0, 8'h78, nb); m_data(8'h78);
        peek(0, v);
        n_vec++;
        if (v !== mem[0]) begin n_err++; $display("FAIL dec_char: %h required %h", v, mem[0]); end
        n_vec++;
        if (cursor_addr !== m_ac) begin n_err++; $display("FAIL dec_wrap_67: %h required %h", cursor_addr, m_ac); end
        bus_op(0, 0, 8'h14, nb); m_cmd(8'h14);
        n_vec++;
        if (cursor_addr !== m_ac) begin n_err++; $display("FAIL shift_wrap_00: %h required %h", cursor_addr, m_ac); end
        bus_op(0, 0, 8'h06, nb); m_cmd(8'h06);
    endtask

    task automatic test_back_to_back();
        int nb, e0;
        logic [7:0] v;
        bus_op(0, 0, 8'h85, nb); m_cmd(8'h85);
        e0 = err_pulses;
        rs_pin = 1; rw_pin = 0; data_in = 8'h4D; en_pin = 1;
        repeat (3) @(negedge clk);
        en_pin = 0;
        repeat (6) @(negedge clk);
        data_in = 8'h4E; en_pin = 1;
        repeat (4) @(negedge clk);
        en_pin = 0;
        m_data(8'h4D);
        repeat (6) @(negedge clk);
        wait_idle("b2b_idle");
        repeat (2) @(negedge clk);
        n_vec++;
        if (err_pulses - e0 != 1) begin n_err++; $display("FAIL b2b_bus_err: %0d pulse cycles required 1", err_pulses - e0); end
        peek(5, v);
        n_vec++;
        if (v !== mem[5]) begin n_err++; $display("FAIL b2b_cell5: %h required %h", v, mem[5]); end
        peek(6, v);
        n_vec++;
        if (v !== mem[6]) begin n_err++; $display("FAIL b2b_cell6: %h required %h", v, mem[6]); end
        n_vec++;
        if (cursor_addr !== m_ac) begin n_err++; $display("FAIL b2b_ac: %h required %h", cursor_addr, m_ac); end
    endtask

    task automatic test_status_read();
        int e0 = err_pulses;
        rs_pin = 1; rw_pin = 0; data_in = 8'h53; en_pin = 1;
        repeat (4) @(negedge clk);
        en_pin = 0;
        m_data(8'h53);
        repeat (6) @(negedge clk);
        n_vec++;
        if (data_oe !== 1'b0) begin n_err++; $display("FAIL stat_oe_pre: %b required 0", data_oe); end
        rs_pin = 0; rw_pin = 1; en_pin = 1;
        repeat (4) @(negedge clk);
        n_vec++;
        if (data_oe !== 1'b1) begin n_err++; $display("FAIL stat_oe_high: %b required 1", data_oe); end
        n_vec++;
        if (data_out !== {1'b1, m_ac}) begin n_err++; $display("FAIL stat_dout: %h required %h", data_out, {1'b1, m_ac}); end
        en_pin = 0;
        repeat (4) @(negedge clk);
        n_vec++;
        if (data_oe !== 1'b0) begin n_err++; $display("FAIL stat_oe_low: %b required 0", data_oe); end
        wait_idle("stat_idle");
        n_vec++;
        if (err_pulses != e0) begin n_err++; $display("FAIL stat_no_err: %0d pulses required 0", err_pulses - e0); end
        rw_pin = 0;
    endtask

    task automatic test_data_read();
        int nb, ix;
        logic [7:0] exp_d;
        logic [7:0] addrs [2] = '{8'h80, 8'hA0};
        foreach (addrs[k]) begin
            bus_op(0, 0, addrs[k], nb); m_cmd(addrs[k]);
            ix = m_idx(m_ac);
            exp_d = (ix < 0) ? 8'h20 : mem[ix];
            rs_pin = 1; rw_pin = 1; en_pin = 1;
            repeat (4) @(negedge clk);
            n_vec++;
            if (data_oe !== 1'b1 || data_out !== exp_d) begin
                n_err++; $display("FAIL data_read[%0d]: oe=%b dout=%h required oe=1 dout=%h", k, data_oe, data_out, exp_d);
            end
            en_pin = 0;
            repeat (5) @(negedge clk);
            wait_idle("rd_idle");
            m_ac = m_next(m_ac, m_id);
            n_vec++;
            if (cursor_addr !== m_ac || data_oe !== 1'b0) begin
                n_err++; $display("FAIL read_advance[%0d]: ac=%h oe=%b required ac=%h oe=0", k, cursor_addr, data_oe, m_ac);
            end
        end
        rw_pin = 0;
    endtask

    task automatic test_random();
        int nb, op;
        logic [7:0] d;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 10);
            if (op <= 2) begin
                d = 8'h80 | 8'($urandom_range(0, 1) * 'h40 + $urandom_range(0, 19));
                bus_op(0, 0, d, nb); m_cmd(d);
            end else if (op == 3) begin
                d = 8'h04 | 8'($urandom_range(0, 3));
                bus_op(0, 0, d, nb); m_cmd(d);
            end else if (op == 4) begin
                d = 8'h10 | 8'($urandom_range(0, 1) << 2);
                bus_op(0, 0, d, nb); m_cmd(d);
            end else if (op == 5) begin
                d = 8'h08 | 8'($urandom_range(0, 7));
                bus_op(0, 0, d, nb); m_cmd(d);
                n_vec++;
                if ({disp_on, cursor_on, blink_on} !== {m_d, m_c, m_b}) begin
                    n_err++; $display("FAIL rnd_dcb[%0d]: %b%b%b required %b%b%b", n, disp_on, cursor_on, blink_on, m_d, m_c, m_b);
                end
            end else begin
                d = 8'($urandom_range(33, 126));
                bus_op(1, 0, d, nb); m_data(d);
            end
            n_vec++;
            if (cursor_addr !== m_ac) begin n_err++; $display("FAIL rnd_ac[%0d] op %0d: %h required %h", n, op, cursor_addr, m_ac); end
        end
    endtask

    task automatic test_ddram_contents();
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            peek(i, v);
            n_vec++;
            if (v !== mem[i]) begin n_err++; $display("FAIL ddram[%0d]: %h required %h", i, v, mem[i]); end
        end
    endtask

    task automatic test_clear();
        int nb;
        bus_op(0, 0, 8'h04, nb); m_cmd(8'h04);
        bus_op(0, 0, 8'h01, nb); m_cmd(8'h01);
        n_vec++;
        if (nb != 1 + 32 + CLEAR_N) begin n_err++; $display("FAIL clear_busy_len: %0d required %0d", nb, 1 + 32 + CLEAR_N); end
        test_ddram_contents();
        bus_op(1, 0, 8'h43, nb); m_data(8'h43);
        n_vec++;
        if (cursor_addr !== m_ac) begin n_err++; $display("FAIL clear_id_restore: %h required %h", cursor_addr, m_ac); end
    endtask

    task automatic test_reset_mid_fill();
        int nb = 0;
        rs_pin = 0; rw_pin = 0; data_in = 8'h01; en_pin = 1;
        repeat (4) @(negedge clk);
        en_pin = 0;
        repeat (15) @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        for (int i = 0; i < 32 + CLEAR_N + 40; i++) begin nb += int'(busy); @(negedge clk); end
        n_vec++;
        if (nb != 32 + CLEAR_N) begin n_err++; $display("FAIL refill_busy_len: %0d required %0d", nb, 32 + CLEAR_N); end
        m_reset();
        test_ddram_contents();
        n_vec++;
        if (cursor_addr !== m_ac) begin n_err++; $display("FAIL refill_ac: %h required %h", cursor_addr, m_ac); end
    endtask

    initial begin
        test_reset();
        test_init_seq();
        test_wrap();
        test_entry_dec();
        test_back_to_back();
        test_status_read();
        test_data_read();
        test_random();
        test_ddram_contents();
        test_clear();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
